// File: rtl/clock_pkg.sv
// Shared types, state encoding and BCD helpers for the multi-alarm clock.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t hh_shi;
    bcd_digit_t hh_ge;
    bcd_digit_t mm_shi;
    bcd_digit_t mm_ge;
    bcd_digit_t ss_shi;
    bcd_digit_t ss_ge;
  } hhmmss_t;

  typedef struct packed {
    bcd_digit_t hh_shi;
    bcd_digit_t hh_ge;
    bcd_digit_t mm_shi;
    bcd_digit_t mm_ge;
  } hhmm_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } alarm_state_t;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;

  // BCD ordering matches numeric ordering once both digits are valid.
  function automatic logic bcd_pair_ok(input logic [7:0] pair, input logic [7:0] max_val);
    logic ok;
    ok = (pair[7:4] <= 4'd9) && (pair[3:0] <= 4'd9) && (pair <= max_val);
    return ok;
  endfunction

  // Returns {pm, hh12} for a valid 24h BCD hour.
  function automatic logic [8:0] hours_12h(input logic [7:0] hh24);
    logic [4:0] bin;
    logic [4:0] rem;
    logic [8:0] res;
    bin = (5'(hh24[7:4]) * 5'd10) + 5'(hh24[3:0]);
    rem = 5'd0;
    if (bin == 5'd0) begin
      res = {1'b0, 8'h12};
    end else if (bin < 5'd12) begin
      res = {1'b0, hh24};
    end else if (bin == 5'd12) begin
      res = {1'b1, 8'h12};
    end else begin
      rem = bin - 5'd12;
      if (rem >= 5'd10) begin
        res = {1'b1, 4'd1, 4'(rem - 5'd10)};
      end else begin
        res = {1'b1, 4'd0, 4'(rem)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD counter that wraps to 00 after MAX_VAL; load has priority over inc.
module bcd_mod_cnt
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = BCD_59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic [7:0] nxt,
  output logic       carry
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next-count and wrap carry
  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      if (cnt_q == MAX_VAL) begin
        cnt_d = 8'h00;
        carry = 1'b1;
      end else if (cnt_q[3:0] == 4'd9) begin
        cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
      end else begin
        cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q   = cnt_q;
  assign nxt = cnt_d;

endmodule

// File: rtl/multi_alarm_clock.sv
// 24h BCD real-time clock with N alarm slots, a ring/snooze/idle alarm FSM
// and a 12h/24h display formatter.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int  CLK_DIV    = 50_000_000,
  parameter int  N_ALARMS   = 4,
  parameter int  RING_SECS  = 60,
  parameter int  SNOOZE_MIN = 5,
  localparam int IW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_time_valid,
  input  logic [23:0]   set_time_bcd,
  input  logic          alarm_wr,
  input  logic [IW-1:0] alarm_idx,
  input  logic [15:0]   alarm_hhmm,
  input  logic          alarm_en,
  input  logic          snooze,
  input  logic          dismiss,
  input  logic          mode_12h,
  output logic [23:0]   time_bcd,
  output logic [23:0]   disp_bcd,
  output logic          pm,
  output logic          sec_tick,
  output logic          ring,
  output logic [IW-1:0] ring_idx,
  output logic          set_err
);

  localparam int PW          = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SNOOZE_SECS = SNOOZE_MIN * 60;
  localparam int CNT_MAX     = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW          = $clog2(CNT_MAX + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic                sec_tick_q, sec_tick_d;
  logic                set_err_q, set_err_d;
  alarm_state_t        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ring_idx_q, ring_idx_d;
  logic                ring_q, ring_d;
  hhmm_t               slot_hhmm_q [N_ALARMS];
  hhmm_t               slot_hhmm_d [N_ALARMS];
  logic [N_ALARMS-1:0] slot_en_q, slot_en_d;

  hhmmss_t    set_s;
  hhmm_t      wr_s;
  logic       tick_s, set_ok_s, load_time_s, adv_s;
  logic       idx_ok_s, wr_ok_s, wr_bad_s, disarm_s;
  logic       new_minute_s, match_s;
  logic [IW-1:0] match_idx_s;
  logic [7:0] sec_q_s, min_q_s, hour_q_s;
  logic [7:0] sec_nxt_s, min_nxt_s, hour_nxt_s;
  logic       sec_carry_s, min_carry_s, day_wrap_unused_s;
  logic [8:0] h12_s;

  assign set_s = hhmmss_t'(set_time_bcd);
  assign wr_s  = hhmm_t'(alarm_hhmm);

  assign tick_s      = (pre_q == PRE_LAST);
  assign set_ok_s    = bcd_pair_ok({set_s.hh_shi, set_s.hh_ge}, BCD_23)
                    && bcd_pair_ok({set_s.mm_shi, set_s.mm_ge}, BCD_59)
                    && bcd_pair_ok({set_s.ss_shi, set_s.ss_ge}, BCD_59);
  assign load_time_s = set_time_valid && set_ok_s;
  // A legal set consumes a coincident tick.
  assign adv_s       = tick_s && !load_time_s;

  if (N_ALARMS == (1 << IW)) begin : g_idx_full
    assign idx_ok_s = 1'b1;
  end else begin : g_idx_part
    assign idx_ok_s = (alarm_idx < IW'(N_ALARMS));
  end

  assign wr_ok_s  = alarm_wr && idx_ok_s
                 && bcd_pair_ok({wr_s.hh_shi, wr_s.hh_ge}, BCD_23)
                 && bcd_pair_ok({wr_s.mm_shi, wr_s.mm_ge}, BCD_59);
  assign wr_bad_s = alarm_wr && !wr_ok_s;
  assign disarm_s = wr_ok_s && !alarm_en && (alarm_idx == ring_idx_q);

  bcd_mod_cnt #(.MAX_VAL(BCD_59)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (adv_s),
    .load     (load_time_s),
    .load_val ({set_s.ss_shi, set_s.ss_ge}),
    .q        (sec_q_s),
    .nxt      (sec_nxt_s),
    .carry    (sec_carry_s)
  );

  bcd_mod_cnt #(.MAX_VAL(BCD_59)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (sec_carry_s),
    .load     (load_time_s),
    .load_val ({set_s.mm_shi, set_s.mm_ge}),
    .q        (min_q_s),
    .nxt      (min_nxt_s),
    .carry    (min_carry_s)
  );

  bcd_mod_cnt #(.MAX_VAL(BCD_23)) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (min_carry_s),
    .load     (load_time_s),
    .load_val ({set_s.hh_shi, set_s.hh_ge}),
    .q        (hour_q_s),
    .nxt      (hour_nxt_s),
    .carry    (day_wrap_unused_s)
  );

  // Prescaler and registered pulse outputs
  always_comb begin
    pre_d = pre_q;
    if (load_time_s || tick_s) begin
      pre_d = {PW{1'b0}};
    end else begin
      pre_d = pre_q + PW'(1);
    end
    sec_tick_d = (pre_d == PRE_LAST);
    set_err_d  = (set_time_valid && !set_ok_s) || wr_bad_s;
  end

  // Alarm slot writes
  always_comb begin
    slot_en_d = slot_en_q;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (wr_ok_s && (alarm_idx == IW'(i))) begin
        slot_hhmm_d[i] = wr_s;
        slot_en_d[i]   = alarm_en;
      end else begin
        slot_hhmm_d[i] = slot_hhmm_q[i];
      end
    end
  end

  // Match against the time about to be entered; descending scan leaves the lowest index.
  always_comb begin
    new_minute_s = adv_s && (sec_nxt_s == 8'h00);
    match_s      = 1'b0;
    match_idx_s  = {IW{1'b0}};
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (slot_en_q[i] && ({hour_nxt_s, min_nxt_s} == slot_hhmm_q[i])) begin
        match_s     = new_minute_s;
        match_idx_s = IW'(i);
      end else begin
        match_s     = match_s;
      end
    end
  end

  // Alarm FSM next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ring_idx_d = ring_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (match_s) begin
          state_d    = ST_RING;
          ring_idx_d = match_idx_s;
          cnt_d      = CW'(RING_SECS);
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RING: begin
        if (dismiss || load_time_s || disarm_s) begin
          state_d = ST_IDLE;
        end else if (snooze) begin
          state_d = ST_SNOOZE;
          cnt_d   = CW'(SNOOZE_SECS);
        end else if (adv_s) begin
          if (cnt_q <= CW'(1)) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - CW'(1);
          end
        end else begin
          state_d = ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (dismiss || load_time_s || disarm_s) begin
          state_d = ST_IDLE;
        end else if (adv_s) begin
          if (cnt_q <= CW'(1)) begin
            state_d = ST_RING;
            cnt_d   = CW'(RING_SECS);
          end else begin
            cnt_d   = cnt_q - CW'(1);
          end
        end else begin
          state_d = ST_SNOOZE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ring_d = (state_d == ST_RING);
  end

  // Control and slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= {PW{1'b0}};
      sec_tick_q  <= 1'b0;
      set_err_q   <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      ring_idx_q  <= {IW{1'b0}};
      ring_q      <= 1'b0;
      slot_hhmm_q <= '{default: hhmm_t'(16'h0000)};
      slot_en_q   <= {N_ALARMS{1'b0}};
    end else begin
      pre_q       <= pre_d;
      sec_tick_q  <= sec_tick_d;
      set_err_q   <= set_err_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ring_idx_q  <= ring_idx_d;
      ring_q      <= ring_d;
      slot_hhmm_q <= slot_hhmm_d;
      slot_en_q   <= slot_en_d;
    end
  end

  assign h12_s    = hours_12h(hour_q_s);
  assign time_bcd = {hour_q_s, min_q_s, sec_q_s};
  assign disp_bcd = mode_12h ? {h12_s[7:0], min_q_s, sec_q_s} : time_bcd;
  assign pm       = mode_12h && h12_s[8];
  assign sec_tick = sec_tick_q;
  assign set_err  = set_err_q;
  assign ring     = ring_q;
  assign ring_idx = ring_idx_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with CLK_DIV=4, RING_SECS=3, SNOOZE_MIN=1.
`timescale 1ns/1ps
module tb_multi_alarm_clock;

  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          set_time_valid;
  logic [23:0]   set_time_bcd;
  logic          alarm_wr;
  logic [IW-1:0] alarm_idx;
  logic [15:0]   alarm_hhmm;
  logic          alarm_en;
  logic          snooze;
  logic          dismiss;
  logic          mode_12h;
  logic [23:0]   time_bcd;
  logic [23:0]   disp_bcd;
  logic          pm;
  logic          sec_tick;
  logic          ring;
  logic [IW-1:0] ring_idx;
  logic          set_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_alarm_clock #(
    .CLK_DIV    (4),
    .N_ALARMS   (4),
    .RING_SECS  (3),
    .SNOOZE_MIN (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_time_valid (set_time_valid),
    .set_time_bcd   (set_time_bcd),
    .alarm_wr       (alarm_wr),
    .alarm_idx      (alarm_idx),
    .alarm_hhmm     (alarm_hhmm),
    .alarm_en       (alarm_en),
    .snooze         (snooze),
    .dismiss        (dismiss),
    .mode_12h       (mode_12h),
    .time_bcd       (time_bcd),
    .disp_bcd       (disp_bcd),
    .pm             (pm),
    .sec_tick       (sec_tick),
    .ring           (ring),
    .ring_idx       (ring_idx),
    .set_err        (set_err)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input logic [23:0] t);
    set_time_valid = 1'b1;
    set_time_bcd   = t;
    cyc(1);
    set_time_valid = 1'b0;
  endtask

  task automatic wr_alarm(input logic [IW-1:0] idx, input logic [15:0] hhmm, input logic en);
    alarm_wr   = 1'b1;
    alarm_idx  = idx;
    alarm_hhmm = hhmm;
    alarm_en   = en;
    cyc(1);
    alarm_wr   = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic d);
    snooze  = s;
    dismiss = d;
    cyc(1);
    snooze  = 1'b0;
    dismiss = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    set_time_valid = 1'b0;
    set_time_bcd   = 24'h000000;
    alarm_wr       = 1'b0;
    alarm_idx      = 2'd0;
    alarm_hhmm     = 16'h0000;
    alarm_en       = 1'b0;
    snooze         = 1'b0;
    dismiss        = 1'b0;
    mode_12h       = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_time",     time_bcd,       24'h000000);
    chk("rst_ring",     24'(ring),      24'd0);
    chk("rst_ring_idx", 24'(ring_idx),  24'd0);
    chk("rst_sec_tick", 24'(sec_tick),  24'd0);
    chk("rst_set_err",  24'(set_err),   24'd0);
    rst_n = 1'b1;

    // Midnight wrap and tick cadence
    set_time(24'h235958);
    chk("set_load",      time_bcd,      24'h235958);
    chk("set_tick0",     24'(sec_tick), 24'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk("tick_cadence", 24'(sec_tick), 24'((k % 4) == 3));
      if (k == 4) chk("time_235959", time_bcd, 24'h235959);
      if (k == 8) chk("time_wrap",   time_bcd, 24'h000000);
    end

    // 12h display
    mode_12h = 1'b1;
    #1;
    chk("disp_00",   disp_bcd, 24'h120000);
    chk("pm_00",     24'(pm),  24'd0);
    set_time(24'h120000);
    chk("disp_12",   disp_bcd, 24'h120000);
    chk("pm_12",     24'(pm),  24'd1);
    set_time(24'h134510);
    chk("disp_13",   disp_bcd, 24'h014510);
    chk("pm_13",     24'(pm),  24'd1);
    set_time(24'h091500);
    chk("disp_09",   disp_bcd, 24'h091500);
    chk("pm_09",     24'(pm),  24'd0);
    set_time(24'h235900);
    chk("disp_23",   disp_bcd, 24'h115900);
    chk("pm_23",     24'(pm),  24'd1);
    mode_12h = 1'b0;
    #1;
    chk("disp_24h",  disp_bcd, 24'h235900);
    chk("pm_24h",    24'(pm),  24'd0);

    // Rejected time set and rejected slot write
    set_time(24'h134510);
    set_time(24'h240000);
    chk("bad_set_err",  24'(set_err), 24'd1);
    chk("bad_set_time", time_bcd,     24'h134510);
    wr_alarm(2'd0, 16'h135A, 1'b1);
    chk("bad_wr_err",   24'(set_err), 24'd1);
    cyc(1);
    chk("err_clear",    24'(set_err), 24'd0);
    chk("bad_time_kept", time_bcd,    24'h134510);

    // Two slots at the same time: lowest wins
    wr_alarm(2'd1, 16'h0730, 1'b1);
    wr_alarm(2'd3, 16'h0730, 1'b1);
    set_time(24'h072959);
    cyc(3);
    chk("pre_match_ring", 24'(ring),     24'd0);
    cyc(1);
    chk("match_ring",     24'(ring),     24'd1);
    chk("match_idx",      24'(ring_idx), 24'd1);
    chk("match_time",     time_bcd,      24'h073000);

    // Snooze for 60 ticks, then ring again, then dismiss
    pulse(1'b1, 1'b0);
    chk("snooze_start",   24'(ring),     24'd0);
    cyc(238);
    chk("snooze_end",     24'(ring),     24'd0);
    cyc(1);
    chk("resnooze_ring",  24'(ring),     24'd1);
    chk("resnooze_idx",   24'(ring_idx), 24'd1);
    chk("resnooze_time",  time_bcd,      24'h073100);
    pulse(1'b0, 1'b1);
    chk("dismiss_ring",   24'(ring),     24'd0);
    chk("dismiss_idx",    24'(ring_idx), 24'd1);
    pulse(1'b1, 1'b0);
    chk("idle_snooze",    24'(ring),     24'd0);

    // Rejected disable write keeps ringing; ring auto-stops after 3 seconds
    set_time(24'h072959);
    cyc(4);
    chk("ring2",          24'(ring),     24'd1);
    wr_alarm(2'd1, 16'h075A, 1'b0);
    chk("ring2_bad_err",  24'(set_err),  24'd1);
    chk("ring2_kept",     24'(ring),     24'd1);
    cyc(10);
    chk("ring2_last",     24'(ring),     24'd1);
    cyc(1);
    chk("ring2_expire",   24'(ring),     24'd0);

    // Snooze and dismiss together: dismiss wins
    set_time(24'h072959);
    cyc(4);
    chk("ring3",          24'(ring),     24'd1);
    pulse(1'b1, 1'b1);
    chk("both_ring",      24'(ring),     24'd0);
    cyc(240);
    chk("both_no_resume", 24'(ring),     24'd0);

    // Legal time set while ringing forces idle
    set_time(24'h072959);
    cyc(4);
    chk("ring4",          24'(ring),     24'd1);
    set_time(24'h120000);
    chk("set_stops_ring", 24'(ring),     24'd0);
    chk("set_stops_time", time_bcd,      24'h120000);

    // Disabling the ringing slot forces idle; slot 3 then takes over
    set_time(24'h072959);
    cyc(4);
    chk("ring5",          24'(ring),     24'd1);
    wr_alarm(2'd1, 16'h0730, 1'b0);
    chk("disarm_ring",    24'(ring),     24'd0);
    chk("disarm_err",     24'(set_err),  24'd0);
    set_time(24'h072959);
    cyc(4);
    chk("ring6",          24'(ring),     24'd1);
    chk("ring6_idx",      24'(ring_idx), 24'd3);

    // Asynchronous reset mid-ring
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ring",     24'(ring),     24'd0);
    chk("async_idx",      24'(ring_idx), 24'd0);
    chk("async_time",     time_bcd,      24'h000000);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameter CLK_DIV, default 50_000_000, clk cycles per second (legal range 2 or more).
REQ-002 Parameter N_ALARMS, default 4, number of alarm slots (legal range 1..16).
REQ-003 Parameter RING_SECS, default 60, ring duration before auto-stop.
REQ-004 Parameter SNOOZE_MIN, default 5, snooze length in minutes (legal range 1..59).
REQ-005 Localparam IW = max(1, clog2(N_ALARMS)), the alarm index width.
REQ-006 Port clk, input, 1, sole clock; the design is fully synchronous to rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port set_time_valid, input, 1, one-cycle request to load set_time_bcd.
REQ-009 Port set_time_bcd, input, 24, {hh_shi, hh_ge, mm_shi, mm_ge, ss_shi, ss_ge} in BCD, 24h format.
REQ-010 Port alarm_wr, input, 1, one-cycle write to alarm slot alarm_idx.
REQ-011 Port alarm_idx, input, IW, slot index.
REQ-012 Port alarm_hhmm, input, 16, alarm time in BCD, 24h format.
REQ-013 Port alarm_en, input, 1, enable bit written with the slot.
REQ-014 Ports snooze and dismiss, input, 1 each, one-cycle user requests.
REQ-015 Port mode_12h, input, 1, display format select (1 selects 12h).
REQ-016 Port time_bcd, output, 24, running time in 24h format.
REQ-017 Port disp_bcd, output, 24, formatted time; port pm, output, 1.
REQ-018 Port sec_tick, output, 1, one-cycle pulse per second.
REQ-019 Ports ring, output, 1, and ring_idx, output, IW, alarm active and its slot.
REQ-020 Port set_err, output, 1, one-cycle pulse when a write is rejected.

Function
REQ-021 Prescaler counts 0..CLK_DIV-1; sec_tick is asserted in the cycle the prescaler equals CLK_DIV-1, and the time advances on that edge.
REQ-022 Time advances as a BCD cascade ss 00..59, mm 00..59, hh 00..23; 23:59:59 wraps to 00:00:00.
REQ-023 A legal set_time_valid (every digit valid BCD, hh ≤ 23, mm ≤ 59, ss ≤ 59) loads the time on the same edge and clears the prescaler.
REQ-024 An illegal set_time_valid leaves time unchanged and pulses set_err in the next cycle.
REQ-025 When set_time_valid and a tick coincide, the set wins and the tick is lost.
REQ-026 alarm_wr stores {alarm_hhmm, alarm_en} into the slot; an illegal hhmm or alarm_idx ≥ N_ALARMS is rejected with set_err and leaves the slot unchanged.
REQ-027 A match occurs on the tick edge whose new time has ss = 00 and hh:mm equal to an enabled slot; if several slots match, the lowest index wins.
REQ-028 The alarm FSM has three states: IDLE, RING and SNOOZE.
REQ-029 IDLE goes to RING on a match, latches ring_idx, and loads the ring counter with RING_SECS.
REQ-030 RING counts down once per tick and returns to IDLE when the counter expires; ring is high exactly RING_SECS seconds.
REQ-031 snooze in RING goes to SNOOZE and loads SNOOZE_MIN*60; when that countdown expires, the FSM re-enters RING with the same ring_idx.
REQ-032 dismiss in RING or SNOOZE goes to IDLE; when snooze and dismiss coincide, dismiss wins.
REQ-033 snooze or dismiss received in IDLE is ignored.
REQ-034 New matches are ignored while in RING or SNOOZE.
REQ-035 A legal time set while in RING or SNOOZE forces IDLE.
REQ-036 A write disabling the slot equal to ring_idx while in RING or SNOOZE forces IDLE.
REQ-037 ring equals (state == RING), registered; ring_idx holds its value in IDLE.
REQ-038 disp_bcd minutes and seconds are identical to time_bcd.
REQ-039 With mode_12h = 0, disp hours equal time hours and pm = 0.
REQ-040 With mode_12h = 1, hours map as follows: 00→12 with pm 0; 01..11 unchanged with pm 0; 12→12 with pm 1; 13..23→01..11 with pm 1.
REQ-041 disp_bcd and pm are combinational from the time registers and mode_12h.

Reset
REQ-042 While rst_n is low, the following hold: time 00:00:00, prescaler 0, every slot 00:00 and disabled, FSM IDLE, ring 0, ring_idx 0, sec_tick 0, set_err 0.
REQ-043 Reset is asserted asynchronously and released synchronously to clk by the integrating level; reset mid-ring drops ring in the same cycle.

Structure
REQ-044 Package clock_pkg holds the BCD digit type, the packed hhmmss and hhmm types, FSM state encoding, and the constants 59 and 23 in BCD.
REQ-045 Sub-module bcd_mod_cnt (two-digit BCD counter with max-value parameter, inc, load and carry-out) is instantiated three times, for sec, min and hour.

Verification
REQ-046 CLK_DIV = 4; set 23:59:58 → after 2 ticks time_bcd reads 00:00:00, with sec_tick every 4th cycle.
REQ-047 Slots 1 and 3 both enabled at 07:30; set 07:29:59; one tick → ring = 1, ring_idx = 1.
REQ-048 In RING, pulse snooze → ring = 0 for SNOOZE_MIN*60 ticks, then ring = 1 with the same idx; then dismiss → IDLE.
REQ-049 Set hh = 24, then write a slot with mm = 0x5A → set_err pulses twice, with time and slot unchanged.
REQ-050 mode_12h = 1 at hours 00, 12 and 13 → disp hours 12/12/01 with pm 0/1/1.
REQ-051 In RING, pulse snooze and dismiss in the same cycle → IDLE; assert rst_n low mid-ring → ring 0 immediately.
